// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared types and SR command codes for the SR-latch pulse driver
package sr_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2,
      CHECK = 2'd3
   } state_t;

   // {s, r} drive codes
   localparam logic [1:0] SR_HOLD    = 2'b00;
   localparam logic [1:0] SR_RST     = 2'b01;
   localparam logic [1:0] SR_SET     = 2'b10;
   localparam logic [1:0] SR_ILLEGAL = 2'b11;

   function automatic int eff_pulse(input int pulse_w);
      return (pulse_w == 0) ? 1 : pulse_w;
   endfunction
endpackage

// File: rtl/sr_pulse_driver_pulse_timer.sv
// rtl/sr_pulse_driver_pulse_timer.sv - loadable down-counter with terminal-count flag
module pulse_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             tc
);
   logic [CNT_W-1:0] count;

   // Holding at zero keeps the counter from ever wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);
endmodule

// File: rtl/sr_pulse_driver.sv
// rtl/sr_pulse_driver.sv - timed, mutually exclusive S/R pulse generator with Q feedback check
module sr_pulse_driver #(
   parameter int PULSE_W = 4,
   parameter int GAP_W   = 2,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   output logic req_ready,
   input  logic req_val,
   output logic s,
   output logic r,
   input  logic q_fb,
   output logic done,
   output logic err,
   input  logic err_clr
);
   import sr_pkg::*;

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(eff_pulse(PULSE_W) - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_W == 0) ? 0 : GAP_W - 1);
   localparam bit               HAS_GAP    = (GAP_W != 0);

   state_t           state, next_state;
   logic             target, target_d;
   logic             accept;
   logic             tc, load, en;
   logic [CNT_W-1:0] load_val;
   logic [1:0]       sr_d;
   logic             done_d, ready_d, err_d;

   assign accept   = req_valid && req_ready;
   assign target_d = accept ? req_val : target;

   pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .en       (en),
      .tc       (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         target    <= 1'b0;
         s         <= 1'b0;
         r         <= 1'b0;
         done      <= 1'b0;
         req_ready <= 1'b1;
         err       <= 1'b0;
      end else begin
         state     <= next_state;
         target    <= target_d;
         {s, r}    <= sr_d;
         done      <= done_d;
         req_ready <= ready_d;
         err       <= err_d;
      end
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      load_val   = PULSE_LOAD;
      en         = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = DRIVE;
               load       = 1'b1;
            end
         end
         DRIVE: begin
            if (tc) begin
               if (HAS_GAP) begin
                  next_state = GAP;
                  load       = 1'b1;
                  load_val   = GAP_LOAD;
               end else begin
                  next_state = CHECK;
               end
            end else begin
               en = 1'b1;
            end
         end
         GAP: begin
            if (tc) next_state = CHECK;
            else    en = 1'b1;
         end
         CHECK:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered pins track the state exactly.
   always_comb begin
      sr_d    = SR_HOLD;
      done_d  = 1'b0;
      ready_d = 1'b0;
      case (next_state)
         IDLE:    ready_d = 1'b1;
         DRIVE:   sr_d    = target_d ? SR_SET : SR_RST;
         CHECK:   done_d  = 1'b1;
         default: sr_d    = SR_HOLD;
      endcase
      if ((state == CHECK) && (q_fb != target)) err_d = 1'b1;
      else if (err_clr)                          err_d = 1'b0;
      else                                       err_d = err;
   end
endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb/tb_sr_pulse_driver.sv - self-checking bench for sr_pulse_driver
module tb_sr_pulse_driver;
   import sr_pkg::*;

   localparam int P   = 4;
   localparam int G   = 2;
   localparam int LAT = P + G + 1;

   logic clk = 1'b0;
   logic rst_n;
   logic req_valid, req_ready, req_val, s, r, q_fb, done, err, err_clr;
   logic req_valid0, req_ready0, req_val0, s0, r0, q_fb0, done0, err0, err_clr0;

   int checks = 0;
   int errors = 0;
   logic err_m;
   logic prev_done  = 1'b0;
   logic prev_done0 = 1'b0;

   always #5 clk = ~clk;

   sr_pulse_driver #(.PULSE_W(P), .GAP_W(G), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_val(req_val), .s(s), .r(r), .q_fb(q_fb), .done(done), .err(err), .err_clr(err_clr)
   );

   sr_pulse_driver #(.PULSE_W(0), .GAP_W(0), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_val(req_val0), .s(s0), .r(r0), .q_fb(q_fb0), .done(done0), .err(err0), .err_clr(err_clr0)
   );

   typedef struct {
      logic v;
      logic q;
      logic clr;
      logic exp_err;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {s,r,done,ready,err}=%b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [4:0] obs();
      return {s, r, done, req_ready, err};
   endfunction

   function automatic logic [4:0] obs0();
      return {s0, r0, done0, req_ready0, err0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Invariants on every cycle, sampled mid-cycle.
   always @(negedge clk) begin
      checks++;
      if ({s, r} == SR_ILLEGAL || {s0, r0} == SR_ILLEGAL ||
          (done && prev_done) || (done0 && prev_done0)) begin
         errors++;
         $display("FAIL invariant: s,r=%b%b s0,r0=%b%b done=%b/%b done0=%b/%b",
                  s, r, s0, r0, prev_done, done, prev_done0, done0);
      end
      prev_done  = done;
      prev_done0 = done0;
   end

   // One request on the default instance; req_val and q_fb are scrambled outside CHECK.
   task automatic run_req(input logic v, input logic q, input logic clr,
                          input logic e_before, input logic e_after, input string tag);
      logic [1:0] sr;
      chk({tag, "_idle"}, obs(), {SR_HOLD, 1'b0, 1'b1, e_before});
      req_valid = 1'b1;
      req_val   = v;
      q_fb      = ~q;
      tick();
      req_valid = 1'b0;
      req_val   = ~v;
      for (int c = 1; c <= LAT + 1; c++) begin
         sr = (c <= P) ? (v ? SR_SET : SR_RST) : SR_HOLD;
         chk($sformatf("%s_c%0d", tag, c), obs(),
             {sr, 1'(c == LAT), 1'(c == LAT + 1), (c == LAT + 1) ? e_after : e_before});
         q_fb    = (c == LAT) ? q : ~q;
         err_clr = (c == LAT) ? clr : 1'b0;
         tick();
      end
      err_clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acc[$];
      int k, cyc, ph, acc_n, done_n;
      logic tgt, e, ex_ready;
      logic [1:0] ex_sr;

      rst_n = 1'b0;
      {req_valid, req_val, q_fb, err_clr} = '0;
      {req_valid0, req_val0, q_fb0, err_clr0} = '0;
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1};

      tick();
      tick();
      chk("reset_state", obs(), {SR_HOLD, 1'b0, 1'b1, 1'b0});
      chk("reset_state0", obs0(), {SR_HOLD, 1'b0, 1'b1, 1'b0});
      rst_n = 1'b1;
      tick();
      chk("reset_exit", obs(), {SR_HOLD, 1'b0, 1'b1, 1'b0});

      err_m = 1'b0;
      foreach (tbl[i]) begin
         run_req(tbl[i].v, tbl[i].q, tbl[i].clr, err_m, tbl[i].exp_err, $sformatf("tbl%0d", i));
         err_m = tbl[i].exp_err;
      end

      // err_clr while idle
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("idle_clr", obs(), {SR_HOLD, 1'b0, 1'b1, 1'b0});

      // req_valid held high: accepts spaced by LAT+1 cycles
      req_valid = 1'b1;
      req_val   = 1'b1;
      q_fb      = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (req_ready) acc.push_back(c);
         tick();
      end
      req_valid = 1'b0;
      repeat (LAT + 1) tick();
      chk_int("busy_accepts", acc.size(), 5);
      for (int i = 1; i < acc.size(); i++)
         chk_int($sformatf("busy_gap%0d", i), acc[i] - acc[i-1], LAT + 1);

      // reset in the middle of DRIVE
      req_valid = 1'b1;
      req_val   = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      chk("pre_rst_drive", obs(), {SR_SET, 1'b0, 1'b0, 1'b0});
      #2 rst_n = 1'b0;
      #1 chk("async_rst", obs(), {SR_HOLD, 1'b0, 1'b1, 1'b0});
      repeat (2) tick();
      chk("in_rst", obs(), {SR_HOLD, 1'b0, 1'b1, 1'b0});
      rst_n = 1'b1;
      for (int c = 0; c < LAT + 2; c++) begin
         chk($sformatf("post_rst_quiet%0d", c), obs(), {SR_HOLD, 1'b0, 1'b1, 1'b0});
         tick();
      end
      run_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

      // PULSE_W=0, GAP_W=0 instance: 1-cycle pulse, done in cycle 2
      for (int i = 0; i < 2; i++) begin
         req_valid0 = 1'b1;
         req_val0   = 1'(i);
         q_fb0      = 1'(i);
         tick();
         req_valid0 = 1'b0;
         chk($sformatf("min_c1_%0d", i), obs0(), {(i != 0) ? SR_SET : SR_RST, 1'b0, 1'b0, 1'b0});
         tick();
         chk($sformatf("min_c2_%0d", i), obs0(), {SR_HOLD, 1'b1, 1'b0, 1'b0});
         tick();
         chk($sformatf("min_c3_%0d", i), obs0(), {SR_HOLD, 1'b0, 1'b1, 1'b0});
      end

      // random regression against a cycle-offset model
      k = -100; cyc = 0; acc_n = 0; done_n = 0; tgt = 1'b0; e = 1'b0;
      while ((acc_n < 1000 || cyc - k <= LAT + 1) && cyc < 20000) begin
         ph       = cyc - k;
         ex_sr    = (ph >= 1 && ph <= P) ? (tgt ? SR_SET : SR_RST) : SR_HOLD;
         ex_ready = !(ph >= 1 && ph <= LAT);
         chk($sformatf("rand_c%0d", cyc), obs(), {ex_sr, 1'(ph == LAT), ex_ready, e});
         if (done) done_n++;
         q_fb      = 1'($urandom);
         err_clr   = ($urandom_range(0, 15) == 0);
         req_valid = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
         req_val   = 1'($urandom);
         if (ph == LAT && q_fb != tgt) e = 1'b1;
         else if (err_clr)             e = 1'b0;
         if (ex_ready && req_valid) begin
            k   = cyc;
            tgt = req_val;
            acc_n++;
         end
         tick();
         cyc++;
      end
      req_valid = 1'b0;
      err_clr   = 1'b0;
      chk_int("rand_accepts", acc_n, 1000);
      chk_int("rand_done_count", done_n, acc_n);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
